data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 28 ++
 rtl/data_mem_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// Load/store-buffer side of the data memory controller: request, busy and load response.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LSB_ID_WIDTH = 3
);
  logic                    lsb2mem_en;
  logic                    lsb2mem_store_load;
  logic [ADDR_WIDTH-1:0]   lsb2mem_addr;
  logic [31:0]             lsb2mem_val;
  logic [2:0]              lsb2mem_type;
  logic [LSB_ID_WIDTH-1:0] lsb2mem_load_id;
  logic                    mem_busy;
  logic                    mem2lsb_load_en;
  logic [LSB_ID_WIDTH-1:0] mem2lsb_load_id;
  logic [31:0]             mem2lsb_load_val;

  modport master (
    output lsb2mem_en, lsb2mem_store_load, lsb2mem_addr, lsb2mem_val,
           lsb2mem_type, lsb2mem_load_id,
    input  mem_busy, mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val
  );

  modport slave (
    input  lsb2mem_en, lsb2mem_store_load, lsb2mem_addr, lsb2mem_val,
           lsb2mem_type, lsb2mem_load_id,
    output mem_busy, mem2lsb_load_en, mem2lsb_load_id, mem2lsb_load_val
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-serial data memory controller for B/H/W loads and stores over an 8-bit RAM port.
// Optional macro DMEM_IO_STALL_EN: stall store bytes to the IO window while io_buffer_full is set.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LSB_ID_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  data_mem_ctrl_if.slave        lsb,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             val_q, val_d;
  logic [2:0]              type_q, type_d;
  logic [LSB_ID_WIDTH-1:0] id_q, id_d;

  logic [2:0]              nbytes;
  logic [2:0]              rd_idx;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    io_stall;
  logic                    capture_en;
  logic                    load_fire;
  logic [31:0]             rd_data;
  logic [31:0]             load_ext;

  function automatic logic [2:0] byte_count(input logic [2:0] t);
    case (t)
      3'b000, 3'b100: return 3'd1;
      3'b001, 3'b101: return 3'd2;
      default:        return 3'd4;
    endcase
  endfunction

  assign nbytes  = byte_count(type_q);
  assign wr_addr = addr_q + ADDR_WIDTH'(cnt_q);

`ifdef DMEM_IO_STALL_EN
  assign io_stall = io_buffer_full && (wr_addr[17:16] == 2'b11);
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall              = 1'b0;
`endif

  // Byte k arrives on mem_din the cycle after its address, i.e. when cnt_q == k+1.
  assign capture_en = (state_q == S_READ) && rdy_in && !flush && (cnt_q != 3'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] byte_q;
      logic       lane_we;

      assign lane_we = capture_en && (cnt_q == 3'(gi + 1));

      always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
          byte_q <= 8'h00;
        end else if (lane_we) begin
          byte_q <= mem_din;
        end
      end

      assign rd_data[gi*8 +: 8] = byte_q;
    end
  endgenerate

  always_comb begin
    case (type_q)
      3'b000:  load_ext = {{24{rd_data[7]}}, rd_data[7:0]};
      3'b100:  load_ext = {24'h000000, rd_data[7:0]};
      3'b001:  load_ext = {{16{rd_data[15]}}, rd_data[15:0]};
      3'b101:  load_ext = {16'h0000, rd_data[15:0]};
      default: load_ext = rd_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    val_d   = val_q;
    type_d  = type_q;
    id_d    = id_q;
    if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          if (lsb.lsb2mem_en && !flush) begin
            addr_d  = lsb.lsb2mem_addr;
            val_d   = lsb.lsb2mem_val;
            type_d  = lsb.lsb2mem_type;
            id_d    = lsb.lsb2mem_load_id;
            cnt_d   = 3'd0;
            state_d = lsb.lsb2mem_store_load ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
          end else if (cnt_q == nbytes) begin
            state_d = S_DONE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_WRITE: begin
          // A store that has started always finishes; flush does not apply here.
          if (!io_stall) begin
            if (cnt_q == nbytes - 3'd1) begin
              state_d = S_IDLE;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      val_q   <= 32'h0;
      type_q  <= 3'b000;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      type_q  <= type_d;
      id_q    <= id_d;
    end
  end

  // While frozen, keep re-reading the last issued byte so mem_din still holds it on resume.
  always_comb begin
    if (rdy_in && (cnt_q < nbytes)) begin
      rd_idx = cnt_q;
    end else if (cnt_q != 3'd0) begin
      rd_idx = cnt_q - 3'd1;
    end else begin
      rd_idx = 3'd0;
    end
  end

  always_comb begin
    case (state_q)
      S_READ:  mem_a = addr_q + ADDR_WIDTH'(rd_idx);
      S_WRITE: mem_a = wr_addr;
      default: mem_a = '0;
    endcase
  end

  assign mem_wr    = (state_q == S_WRITE) && rdy_in && !io_stall;
  assign mem_dout  = mem_wr ? val_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign load_fire = (state_q == S_DONE) && rdy_in && !flush;

  assign lsb.mem_busy         = (state_q != S_IDLE);
  assign lsb.mem2lsb_load_en  = load_fire;
  assign lsb.mem2lsb_load_id  = load_fire ? id_q : '0;
  assign lsb.mem2lsb_load_val = load_fire ? load_ext : 32'h0;

endmodule
